alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester front end for the shared 32-bit combinational `alu`. Each requester presents operands and a 4-bit opcode with a valid/ready handshake. The block picks one request per cycle using round-robin priority and drives the granted operands into its internal `alu` instance. It registers the result into a single-entry response buffer, tagged with the requester id, and holds it under downstream back-pressure.

## Interface
- `DATA_W`, 32: operand/result width; fixed at 32 to match `alu`.
- `OPR_W`, 4: opcode width; fixed at 4 to match `alu`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req0_valid`  in  1  requester 0 has a pending operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  32  requester 0 operands.
- `req0_opr`  in  4  requester 0 opcode, passed unmodified to `alu`.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_opr`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  response buffer holds a result.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_result`  out  32  registered `alu` result.
- `rsp_id`  out  1  requester that issued the result (0/1).

## Operation
- Opcodes are opaque to the arbiter and forwarded bit-exact. The `alu` encodings are:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, OR 0110, AND 0111, SRA 1101
- Buffer state machine has two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - EMPTY goes to FULL on a grant.
  - FULL goes to EMPTY on `rsp_ready` with no grant.
  - FULL stays FULL on `rsp_ready` with a grant; the buffer is replaced with the new result.
  - FULL stays FULL on no `rsp_ready`; the buffer holds.
- Accept enable: `can_accept = !rst && (!rsp_valid || rsp_ready)`.
- Arbitration is evaluated only when `can_accept`=1:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted most recently (pointer `last_id`).
  - Neither valid: no grant; `last_id` unchanged.
- `reqN_ready` = `can_accept` && grant to N. It is combinational from the valids, `rsp_valid`, `rsp_ready` and `rst`.
  - At most one ready is high per cycle.
  - Ready is never high for a requester whose valid is low.
- Requesters must not make `valid` depend on `ready`. Operands and opcode must be held stable while valid and not ready.
- On a grant:
  - The mux selects the granted a/b/opr into `alu`.
  - `rsp_result` <= `alu` result, `rsp_id` <= granted id, `last_id` <= granted id.
- No result is dropped or duplicated. Each accepted request produces exactly one response, in acceptance order.

## Timing
- Reset values: `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `last_id`=1, so requester 0 wins the first tie.
- During any cycle with `rst`=1: `req0_ready` = `req1_ready` = 0.
- Reset mid-operation: any held response is discarded. `rsp_valid` is 0 in the cycle after the reset edge.
- Latency: a request accepted at edge N shows `rsp_valid`=1 with its result in the cycle following edge N, i.e. 1 cycle.
- Throughput: one operation per cycle while `rsp_ready`=1. Under sustained two-way contention, grants alternate 0,1,0,1.
- Back-pressure: while FULL and `rsp_ready`=0, both readys are 0 and `rsp_result`/`rsp_id` are stable.
- Simultaneous `rsp_ready` and new grant in a FULL cycle: the old response is consumed at the edge and the new response is visible the next cycle, with no bubble.
- The round-robin pointer updates only on an actual grant. An idle or stalled cycle does not change priority.

## Test plan
- Single request, idle: req0 ADD a=10 b=5, `rsp_ready`=1.
  - `req0_ready`=1 the same cycle.
  - Next cycle: `rsp_valid`=1, `rsp_result`=15, `rsp_id`=0.
- First tie after reset: req0 SUB 10,5 and req1 SLL 1,3 both valid.
  - Cycle 1: req0 granted; response 5, id 0.
  - Cycle 2: req1 granted; response 8, id 1.
- Sustained contention: both valid for 6 cycles, `rsp_ready`=1; req0 XOR F0F0F0F0^0F0F0F0F, req1 AND FF00FF00&0F0F0F0F.
  - Response ids are 0,1,0,1,0,1 on consecutive cycles.
  - Results alternate FFFFFFFF / 0F000F00.
- Back-pressure: req1 SRA a=-8 b=2 accepted, then `rsp_ready`=0 for 3 cycles while req0 SLTU FFFFFFFF,1 is valid.
  - `rsp_result`=FFFFFFFE, id 1, held for 3 cycles; both readys are 0.
  - When `rsp_ready` rises, req0 is accepted the same cycle. Next response is 0, id 0.
- Reset mid-operation: response FULL (SLT -1,1 gives 1), `rsp_ready`=0, then assert `rst` one cycle with both valids high.
  - Readys are 0 during reset.
  - Next cycle: `rsp_valid`=0, `rsp_result`=0.
  - The first post-reset tie grants req0.
- No spurious grants: neither requester valid for 4 cycles.
  - `rsp_valid` stays 0; `last_id` is unchanged, confirmed by the winner of the subsequent tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for a shared combinational alu
// with a single-entry tagged response buffer.

module alu #(
   parameter int DATA_W = 32,
   parameter int OPR_W  = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OPR_W-1:0]  opr,
   output logic [DATA_W-1:0] result
);
   logic [4:0] shamt;
   assign shamt = b[4:0];
   always_comb begin
      result = '0;
      case (opr)
         4'b0000: result = a + b;
         4'b1000: result = a - b;
         4'b0001: result = a << shamt;
         4'b0010: result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
         4'b0011: result = {{(DATA_W-1){1'b0}}, a < b};
         4'b0100: result = a ^ b;
         4'b0101: result = a >> shamt;
         4'b0110: result = a | b;
         4'b0111: result = a & b;
         4'b1101: result = $signed(a) >>> shamt;
         default: result = '0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OPR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OPR_W-1:0]  req0_opr,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OPR_W-1:0]  req1_opr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_id
);
   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state, state_nx;
   logic              last_id;
   logic              can_accept;
   logic              grant;
   logic              gnt_id;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [OPR_W-1:0]  alu_opr;

   assign rsp_valid  = (state == FULL);
   assign can_accept = !rst && (!rsp_valid || rsp_ready);

   // On a tie the requester that did not win last time gets the grant.
   assign req0_ready = can_accept && req0_valid && (!req1_valid || last_id);
   assign req1_ready = can_accept && req1_valid && (!req0_valid || !last_id);
   assign grant      = req0_ready || req1_ready;
   assign gnt_id     = req1_ready;

   assign alu_a   = gnt_id ? req1_a   : req0_a;
   assign alu_b   = gnt_id ? req1_b   : req0_b;
   assign alu_opr = gnt_id ? req1_opr : req0_opr;

   alu #(.DATA_W(DATA_W), .OPR_W(OPR_W)) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .opr    (alu_opr),
      .result (alu_result)
   );

   always_comb begin
      state_nx = state;
      if (grant)
         state_nx = FULL;
      else if (rsp_ready)
         state_nx = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         rsp_result <= '0;
         rsp_id     <= 1'b0;
         last_id    <= 1'b1;
      end else begin
         state <= state_nx;
         if (grant) begin
            rsp_result <= alu_result;
            rsp_id     <= gnt_id;
            last_id    <= gnt_id;
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with a response scoreboard popped by a monitor.

module tb_alu_arbiter;
   logic        clk = 0;
   logic        rst = 1;
   logic        req0_valid = 0, req1_valid = 0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [3:0]  req0_opr = 0, req1_opr = 0;
   logic        rsp_valid, rsp_ready = 0;
   logic [31:0] rsp_result;
   logic        rsp_id;

   int checks = 0;
   int errors = 0;
   logic [32:0] q[$];

   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SLT = 4'b0010,
      SLTU = 4'b0011, XOR = 4'b0100, SRL = 4'b0101, OR = 4'b0110, AND = 4'b0111, SRA = 4'b1101;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_opr   (req0_opr),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_opr   (req1_opr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_id     (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rsp: got id %0d result %h expected none", rsp_id, rsp_result);
         end else begin
            logic [32:0] e;
            e = q.pop_front();
            chk("rsp_id", {31'b0, rsp_id}, {31'b0, e[32]});
            chk("rsp_result", rsp_result, e[31:0]);
         end
      end
   end

   task automatic step(input logic v0, input logic v1, input logic rr,
                       input logic e0, input logic e1,
                       input logic [31:0] x0, input logic [31:0] x1);
      req0_valid = v0;
      req1_valid = v1;
      rsp_ready  = rr;
      @(negedge clk);
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
      if (e0) q.push_back({1'b0, x0});
      if (e1) q.push_back({1'b1, x1});
      @(posedge clk);
      #1;
   endtask

   task automatic op0(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      req0_opr = o; req0_a = a; req0_b = b;
   endtask

   task automatic op1(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      req1_opr = o; req1_a = a; req1_b = b;
   endtask

   initial begin
      // Reset with both requesters valid: no grants, clean reset state.
      rst = 1;
      step(1, 1, 1, 0, 0, 0, 0);
      chk("reset_valid", {31'b0, rsp_valid}, 0);
      chk("reset_result", rsp_result, 0);
      chk("reset_id", {31'b0, rsp_id}, 0);
      rst = 0;

      // First tie after reset goes to req0, then req1.
      op0(SUB, 10, 5);
      op1(SLL, 1, 3);
      step(1, 1, 1, 1, 0, 32'd5, 32'd8);
      step(0, 1, 1, 0, 1, 32'd5, 32'd8);

      // Sustained contention alternates 0,1,0,1,0,1.
      op0(XOR, 32'hF0F0F0F0, 32'h0F0F0F0F);
      op1(AND, 32'hFF00FF00, 32'h0F0F0F0F);
      for (int i = 0; i < 6; i++)
         step(1, 1, 1, (i % 2) == 0, (i % 2) == 1, 32'hFFFFFFFF, 32'h0F000F00);

      // Single request while idle.
      op0(ADD, 10, 5);
      step(1, 0, 1, 1, 0, 32'd15, 0);

      // Back-pressure: SRA response held while SLTU waits.
      op1(SRA, 32'hFFFFFFF8, 2);
      step(0, 1, 1, 0, 1, 0, 32'hFFFFFFFE);
      op0(SLTU, 32'hFFFFFFFF, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         chk("hold_valid", {31'b0, rsp_valid}, 1);
         chk("hold_result", rsp_result, 32'hFFFFFFFE);
         chk("hold_id", {31'b0, rsp_id}, 1);
      end
      step(1, 0, 1, 1, 0, 32'd0, 0);

      // Reset while a response is held under back-pressure.
      op0(SLT, 32'hFFFFFFFF, 1);
      step(1, 0, 1, 1, 0, 32'd1, 0);
      rst = 1;
      step(1, 1, 0, 0, 0, 0, 0);
      q.delete();
      rst = 0;
      chk("postrst_valid", {31'b0, rsp_valid}, 0);
      chk("postrst_result", rsp_result, 0);
      op0(OR, 32'h0F0, 32'hF00);
      op1(SRL, 32'h80000000, 4);
      step(1, 1, 1, 1, 0, 32'hFF0, 32'h08000000);
      step(0, 1, 1, 0, 1, 0, 32'h08000000);
      step(0, 0, 1, 0, 0, 0, 0);

      // Idle cycles: no responses, priority unchanged (req1 won last).
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0, 0, 0);
         chk("idle_valid", {31'b0, rsp_valid}, 0);
      end
      op1(SUB, 3, 5);
      step(1, 1, 1, 1, 0, 32'hFF0, 32'hFFFFFFFE);
      step(0, 1, 1, 0, 1, 0, 32'hFFFFFFFE);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);

      chk("drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
